// File: rtl/fifo_almost_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_almost_param
// Purpose  : Single-clock synchronous FIFO with runtime-programmable
//            almost-full / almost-empty thresholds, an occupancy count,
//            a read-data valid strobe and a sticky overflow/underflow flag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through: fifo_data_out shows
//                              the head word whenever the FIFO is not empty,
//                              fifo_valid_out = !fifo_empty_out.
//                 undefined -> registered read, data valid one cycle after
//                              an accepted read.
// ----------------------------------------------------------------------------
// Ports:
//   clk              in   clock, rising edge
//   reset            in   synchronous active-high reset
//   fifo_data_in     in   write data               [DATA_BITS]
//   fifo_write       in   write request
//   fifo_read        in   read request
//   high_limit       in   almost-full threshold    [ADDR_BITS+1], 0 -> HIGH_DEF
//   low_limit        in   almost-empty threshold   [ADDR_BITS+1], 0 -> LOW_DEF
//   fifo_data_out    out  read data                [DATA_BITS]
//   fifo_valid_out   out  fifo_data_out holds a popped / head word
//   fifo_full_out    out  count == depth
//   fifo_empty_out   out  count == 0
//   almost_full_out  out  count >= effective high threshold
//   almost_empty_out out  count <= effective low threshold
//   error_fifo_out   out  sticky overflow/underflow flag
//   fifo_count_out   out  occupancy 0..depth       [ADDR_BITS+1]
// ============================================================================
module fifo_almost_param #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3,
    parameter int HIGH_DEF  = 6,
    parameter int LOW_DEF   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    input  logic                 fifo_write,
    input  logic                 fifo_read,
    input  logic [ADDR_BITS:0]   high_limit,
    input  logic [ADDR_BITS:0]   low_limit,
    output logic [DATA_BITS-1:0] fifo_data_out,
    output logic                 fifo_valid_out,
    output logic                 fifo_full_out,
    output logic                 fifo_empty_out,
    output logic                 almost_full_out,
    output logic                 almost_empty_out,
    output logic                 error_fifo_out,
    output logic [ADDR_BITS:0]   fifo_count_out
);

    localparam int                 c_DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] c_DEPTH_CNT = (ADDR_BITS+1)'(c_DEPTH);
    localparam logic [ADDR_BITS:0] c_HIGH_DEF  = (ADDR_BITS+1)'(HIGH_DEF);
    localparam logic [ADDR_BITS:0] c_LOW_DEF   = (ADDR_BITS+1)'(LOW_DEF);

    // Storage (not reset: stale contents are unreachable once pointers clear)
    logic [DATA_BITS-1:0] r_mem [0:c_DEPTH-1];

    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_almost_full;
    logic                 r_almost_empty;
    logic                 r_error;

    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_overflow;
    logic                 w_underflow;
    logic [ADDR_BITS:0]   w_count_nxt;
    logic [ADDR_BITS:0]   w_high_eff;
    logic [ADDR_BITS:0]   w_low_eff;

    // ------------------------------------------------------------------------
    // Request qualification. A read is only ever refused for emptiness; a
    // write at full is allowed when a read frees a slot on the same edge.
    // There is no bypass path, so a write into an empty FIFO never satisfies
    // a simultaneous read.
    // ------------------------------------------------------------------------
    assign w_rd_acc    = fifo_read  & ~r_empty;
    assign w_wr_acc    = fifo_write & (~r_full | w_rd_acc);
    assign w_overflow  = fifo_write & ~w_wr_acc;
    assign w_underflow = fifo_read  & r_empty;

    assign w_high_eff  = (high_limit == '0) ? c_HIGH_DEF : high_limit;
    assign w_low_eff   = (low_limit  == '0) ? c_LOW_DEF  : low_limit;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pointers, count and status. Flags are registered from the next count so
    // they describe the occupancy after this edge; thresholds are re-sampled
    // every cycle so a threshold change takes effect on the next edge even
    // without traffic. Pointers wrap naturally because depth is 2**ADDR_BITS.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_error        <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == c_DEPTH_CNT);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= w_high_eff);
            r_almost_empty <= (w_count_nxt <= w_low_eff);
            if (w_overflow || w_underflow) begin
                r_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= fifo_data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented combinationally from storage; a word written
    // into an empty FIFO shows up as soon as the write edge updates count.
    assign fifo_data_out  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign fifo_valid_out = ~r_empty;
`else
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_valid_out;

    // Registered read: the popped word is held until the next accepted read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    assign fifo_data_out  = r_data_out;
    assign fifo_valid_out = r_valid_out;
`endif

    assign fifo_full_out    = r_full;
    assign fifo_empty_out   = r_empty;
    assign almost_full_out  = r_almost_full;
    assign almost_empty_out = r_almost_empty;
    assign error_fifo_out   = r_error;
    assign fifo_count_out   = r_count;

endmodule
`default_nettype wire

// File: doc/fifo_almost_param.md
Name: fifo_almost_param

Overview:
Parametrised synchronous FIFO with runtime-programmable almost-full and almost-empty thresholds. It also provides an occupancy count, a registered read-data valid strobe and a sticky overflow/underflow error flag. It is the next generation of the project's almost-threshold FIFO and sits between producer and consumer stages in the datapath, in a single clock domain.

Parameters:
DATA_BITS, 10, data word width
ADDR_BITS, 3, pointer width; depth = 2**ADDR_BITS (default 8)
HIGH_DEF, 6, reset value of the internal high threshold when high_limit is 0
LOW_DEF, 2, reset value of the internal low threshold when low_limit is 0

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
fifo_data_in  input  DATA_BITS  write data
fifo_write  input  1  write request
fifo_read  input  1  read request
high_limit  input  ADDR_BITS+1  almost-full threshold; 0 selects HIGH_DEF
low_limit  input  ADDR_BITS+1  almost-empty threshold; 0 selects LOW_DEF
fifo_data_out  output  DATA_BITS  read data
fifo_valid_out  output  1  fifo_data_out holds a newly popped word
fifo_full_out  output  1  count == depth
fifo_empty_out  output  1  count == 0
almost_full_out  output  1  count >= effective high threshold
almost_empty_out  output  1  count <= effective low threshold
error_fifo_out  output  1  sticky overflow/underflow flag
fifo_count_out  output  ADDR_BITS+1  occupancy, 0..depth

Behaviour:
- Reset (reset=1 at a clk edge) clears the following:
  - write/read pointers and count = 0
  - fifo_data_out = 0, fifo_valid_out = 0, error_fifo_out = 0
  - fifo_full_out = 0, fifo_empty_out = 1, almost_full_out = 0, almost_empty_out = 1
- Reset mid-operation discards all stored data. Memory contents need not be cleared.
- Status outputs are registered and reflect the count after the current edge's operations.
- Write accepted when fifo_write=1 and (not full, or fifo_read=1 with a read accepted in the same cycle).
  - The word is stored at the write pointer, which increments modulo depth.
- Read accepted when fifo_read=1 and not empty.
  - The head word is registered onto fifo_data_out with fifo_valid_out=1 the next cycle (latency 1).
  - The read pointer increments modulo depth.
- No accepted read: fifo_valid_out=0 and fifo_data_out holds its last value.
- Count update: +1 on write-only, -1 on read-only, unchanged on simultaneous accept.
- Full with write and read in the same cycle: both accepted, count stays at depth, no error.
- Empty with write and read in the same cycle: write accepted, read rejected, error set, count becomes 1. No bypass.
- Overflow: write while full without an accepted read. Data is dropped, error_fifo_out is set, state is otherwise unchanged.
- Underflow: read while empty. The read is ignored, error_fifo_out is set, fifo_valid_out=0.
- error_fifo_out stays high until reset.
- Thresholds are sampled every cycle; they are not latched.
  - A threshold above depth means almost_full_out never asserts.
  - low >= depth means almost_empty_out is always 1.
- Pointer wrap: full/empty are derived from the count, never from pointer equality alone.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through mode.
  - fifo_data_out presents the head word whenever not empty.
  - fifo_valid_out = !fifo_empty_out.
  - fifo_read acknowledges and pops the head; the next word appears on the following cycle.
  - A write to an empty FIFO is visible on fifo_data_out one cycle after the write edge.
  - Error, count and flag rules are unchanged.
- Undefined: the registered read with 1-cycle latency described above.

Test Plan:
1. Reset, then high_limit=6, low_limit=2 and 8 back-to-back writes of 0x101..0x108:
   - count goes 1..8
   - almost_empty_out falls when count reaches 3
   - almost_full_out rises when count reaches 6
   - fifo_full_out=1 at count 8; error stays 0
2. Then 8 reads:
   - fifo_data_out shows 0x101..0x108 in order, each with fifo_valid_out=1 one cycle after its read
   - fifo_empty_out=1 after the last read; almost flags return to 0/1
3. Overflow: fill to 8, then write 0x3FF with read=0:
   - error_fifo_out=1, count stays 8
   - subsequent reads return 0x101..0x108; 0x3FF is never output
4. Simultaneous write and read at full, and at 3 words:
   - count unchanged, no error, data order preserved across a pointer wrap
5. Underflow: read on an empty FIFO with write=1, data 0x055:
   - error=1, count=1, fifo_valid_out=0
   - the next read returns 0x055
6. Reset asserted mid-fill at count=5:
   - next cycle count=0, empty=1, error=0
   - a following read raises error
   - with FIFO_FWFT_EN defined, rerun 1–2 and check head data with zero read latency
